// File: rtl/tiny_alu_pkg.sv
// Shared opcodes, issuer state encoding and command layout for the tiny ALU.
package tiny_alu_pkg;

   localparam int unsigned DATA_W = 8;

   localparam logic [2:0] OP_NOP = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_XOR = 3'd3;
   localparam logic [2:0] OP_MUL = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } issuer_state_t;

   typedef struct packed {
      logic [2:0]        op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } cmd_t;

   // Opcodes 0..4 are implemented by the ALU; 5..7 are rejected.
   function automatic logic is_legal_op(input logic [2:0] op);
      return (op <= OP_MUL);
   endfunction

endpackage

// File: rtl/tiny_alu_cmd_fifo.sv
// Synchronous command FIFO; extra pointer bit distinguishes full from empty.
module tiny_alu_cmd_fifo #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ENTRY_W    = 19
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_push,
   input  logic [ENTRY_W-1:0] i_data,
   input  logic               i_pop,
   output logic [ENTRY_W-1:0] o_data,
   output logic               o_full,
   output logic               o_empty
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
   logic [AW:0]        r_wptr;
   logic [AW:0]        r_rptr;
   logic               w_push_ok;
   logic               w_pop_ok;

   assign o_empty   = (r_wptr == r_rptr);
   assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;
   assign o_data    = r_mem[r_rptr[AW-1:0]];

   // Storage write; contents need no reset since pointers gate visibility.
   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[r_wptr[AW-1:0]] <= i_data;
   end

   // Read/write pointer advance.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + 1'b1;
         if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      end
   end

endmodule

// File: rtl/tiny_alu_cmd_issuer.sv
// Buffers ALU commands, runs the ALU start/done handshake one command at a
// time and returns results (with error flag) over a valid/ready response port.
module tiny_alu_cmd_issuer
   import tiny_alu_pkg::*;
#(
   parameter int unsigned DATA_W      = tiny_alu_pkg::DATA_W,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned TIMEOUT_CYC = 15
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [2:0]          cmd_op,
   input  logic [DATA_W-1:0]   cmd_a,
   input  logic [DATA_W-1:0]   cmd_b,
   output logic                alu_start,
   output logic [2:0]          alu_op,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   input  logic                alu_done,
   input  logic [2*DATA_W-1:0] alu_result,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [2:0]          rsp_op,
   output logic [2*DATA_W-1:0] rsp_result,
   output logic                rsp_err,
   output logic                busy
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   issuer_state_t       r_state, w_state_next;
   cmd_t                w_cmd_in, w_head, r_cmd, w_cmd_next;
   logic                w_push, w_pop, w_full, w_empty, w_timeout;
   logic [CNT_W-1:0]    r_cnt, w_cnt_next;
   logic                r_alu_start, w_alu_start_next;
   logic                r_rsp_valid, w_rsp_valid_next;
   logic [2:0]          r_rsp_op, w_rsp_op_next;
   logic [2*DATA_W-1:0] r_rsp_result, w_rsp_result_next;
   logic                r_rsp_err, w_rsp_err_next;

   assign w_cmd_in  = '{op: cmd_op, a: cmd_a, b: cmd_b};
   assign w_push    = cmd_valid && !w_full;
   assign w_pop     = (r_state == ST_IDLE) && !w_empty;
   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

   tiny_alu_cmd_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .ENTRY_W    ($bits(cmd_t))
   ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .i_push  (w_push),
      .i_data  (w_cmd_in),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_cmd        <= '0;
         r_cnt        <= '0;
         r_alu_start  <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_op     <= '0;
         r_rsp_result <= '0;
         r_rsp_err    <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_cmd        <= w_cmd_next;
         r_cnt        <= w_cnt_next;
         r_alu_start  <= w_alu_start_next;
         r_rsp_valid  <= w_rsp_valid_next;
         r_rsp_op     <= w_rsp_op_next;
         r_rsp_result <= w_rsp_result_next;
         r_rsp_err    <= w_rsp_err_next;
      end
   end

   // Next-state: NOP/illegal skip the ALU; done wins over a same-cycle timeout.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (!w_empty)
                     w_state_next = (is_legal_op(w_head.op) && (w_head.op != OP_NOP))
                                    ? ST_EXEC : ST_RESP;
         ST_EXEC: if (alu_done || w_timeout) w_state_next = ST_RESP;
         ST_RESP: if (rsp_ready) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs, computed from the coming state.
   always_comb begin
      w_cmd_next        = r_cmd;
      w_cnt_next        = '0;
      w_rsp_op_next     = r_rsp_op;
      w_rsp_result_next = r_rsp_result;
      w_rsp_err_next    = r_rsp_err;
      case (r_state)
         ST_IDLE: if (!w_empty) begin
            w_cmd_next        = w_head;
            w_rsp_op_next     = w_head.op;
            w_rsp_result_next = '0;
            w_rsp_err_next    = !is_legal_op(w_head.op);
         end
         ST_EXEC: begin
            w_cnt_next    = r_cnt + 1'b1;
            w_rsp_op_next = r_cmd.op;
            if (alu_done) begin
               w_rsp_result_next = alu_result;
               w_rsp_err_next    = 1'b0;
            end else if (w_timeout) begin
               w_rsp_result_next = '0;
               w_rsp_err_next    = 1'b1;
            end
         end
         default: ;
      endcase
      w_alu_start_next = (w_state_next == ST_EXEC);
      w_rsp_valid_next = (w_state_next == ST_RESP);
   end

   assign cmd_ready  = !w_full;
   assign busy       = !w_empty || (r_state != ST_IDLE);
   assign alu_start  = r_alu_start;
   assign alu_op     = r_cmd.op;
   assign alu_a      = r_cmd.a;
   assign alu_b      = r_cmd.b;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_op     = r_rsp_op;
   assign rsp_result = r_rsp_result;
   assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_tiny_alu_cmd_issuer.sv
// Directed bench for tiny_alu_cmd_issuer with a behavioural ALU of settable latency.
module tb_tiny_alu_cmd_issuer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [2:0]  cmd_op = '0;
   logic [7:0]  cmd_a = '0;
   logic [7:0]  cmd_b = '0;
   logic        alu_start;
   logic [2:0]  alu_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic        alu_done = 1'b0;
   logic [15:0] alu_result = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [2:0]  rsp_op;
   logic [15:0] rsp_result;
   logic        rsp_err;
   logic        busy;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned alu_lat = 1;
   bit          alu_never = 1'b0;
   int unsigned m_cnt = 0;
   int unsigned start_cycles = 0;

   tiny_alu_cmd_issuer #(
      .DATA_W      (8),
      .FIFO_DEPTH  (4),
      .TIMEOUT_CYC (15)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .alu_start  (alu_start),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_done   (alu_done),
      .alu_result (alu_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_op     (rsp_op),
      .rsp_result (rsp_result),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // ALU model: done is raised in the alu_lat-th cycle that alu_start is high.
   always @(negedge clk) begin
      if (alu_start) begin
         m_cnt = m_cnt + 1;
         alu_done = !alu_never && (m_cnt == alu_lat);
         case (alu_op)
            3'd1: alu_result = {8'h00, alu_a} + {8'h00, alu_b};
            3'd2: alu_result = {8'h00, alu_a & alu_b};
            3'd3: alu_result = {8'h00, alu_a ^ alu_b};
            3'd4: alu_result = alu_a * alu_b;
            default: alu_result = 16'h0;
         endcase
      end else begin
         m_cnt = 0;
         alu_done = 1'b0;
         alu_result = 16'h0;
      end
   end

   always @(negedge clk) if (alu_start) start_cycles = start_cycles + 1;

   // Present one command from a negedge; returns at the negedge after acceptance.
   task automatic push_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int unsigned n = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
      while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin
         n_tests++; n_fail++;
         $display("FAIL push_timeout: cmd_ready stayed %b, required 1", cmd_ready);
      end else begin
         @(posedge clk);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
   endtask

   // Take one response; fields come back as X if none arrives in time.
   task automatic get_rsp(output logic [2:0] op, output logic [15:0] res, output logic err);
      int unsigned n = 0;
      rsp_ready = 1'b1;
      while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
      if (n >= 100) begin
         op = 'x; res = 'x; err = 'x;
      end else begin
         op = rsp_op; res = rsp_result; err = rsp_err;
         @(posedge clk);
         @(negedge clk);
      end
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_tests++;
      if ({cmd_ready, alu_start, rsp_valid, busy} !== 4'b1000) begin
         n_fail++;
         $display("FAIL reset_ctrl: {rdy,start,rvalid,busy}=%b required 1000",
                  {cmd_ready, alu_start, rsp_valid, busy});
      end
      n_tests++;
      if ({alu_op, alu_a, alu_b, rsp_op, rsp_result, rsp_err} !== 39'h0) begin
         n_fail++;
         $display("FAIL reset_data: alu=%h/%h/%h rsp=%h/%h/%b required all 0",
                  alu_op, alu_a, alu_b, rsp_op, rsp_result, rsp_err);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_add();
      logic [2:0] op; logic [15:0] res; logic err;
      int unsigned s0;
      alu_lat = 1; alu_never = 1'b0;
      s0 = start_cycles;
      push_cmd(3'd1, 8'hFF, 8'h01);
      n_tests++;
      if ({busy, alu_start} !== 2'b10) begin
         n_fail++;
         $display("FAIL add_accept: {busy,start}=%b required 10", {busy, alu_start});
      end
      @(negedge clk);
      n_tests++;
      if ({alu_start, alu_op, alu_a, alu_b} !== {1'b1, 3'd1, 8'hFF, 8'h01}) begin
         n_fail++;
         $display("FAIL add_issue: start=%b op=%h a=%h b=%h required 1/1/ff/01",
                  alu_start, alu_op, alu_a, alu_b);
      end
      @(negedge clk);
      n_tests++;
      if ({alu_start, rsp_valid} !== 2'b01) begin
         n_fail++;
         $display("FAIL add_done: {start,rvalid}=%b required 01", {alu_start, rsp_valid});
      end
      get_rsp(op, res, err);
      n_tests++;
      if ({op, res, err} !== {3'd1, 16'h0100, 1'b0}) begin
         n_fail++;
         $display("FAIL add_rsp: op=%h res=%h err=%b required 1/0100/0", op, res, err);
      end
      n_tests++;
      if (start_cycles - s0 != 1) begin
         n_fail++;
         $display("FAIL add_start_len: %0d cycles, required 1", start_cycles - s0);
      end
   endtask

   task automatic test_mul();
      logic [2:0] op; logic [15:0] res; logic err;
      int unsigned s0;
      alu_lat = 3; alu_never = 1'b0;
      s0 = start_cycles;
      push_cmd(3'd4, 8'hFF, 8'hFF);
      get_rsp(op, res, err);
      n_tests++;
      if ({op, res, err} !== {3'd4, 16'hFE01, 1'b0}) begin
         n_fail++;
         $display("FAIL mul_rsp: op=%h res=%h err=%b required 4/fe01/0", op, res, err);
      end
      n_tests++;
      if (start_cycles - s0 != 3) begin
         n_fail++;
         $display("FAIL mul_start_len: %0d cycles, required 3", start_cycles - s0);
      end
   endtask

   task automatic test_nop_illegal();
      logic [2:0] op; logic [15:0] res; logic err;
      int unsigned s0;
      alu_lat = 1;
      s0 = start_cycles;
      push_cmd(3'd0, 8'h12, 8'h34);
      push_cmd(3'd6, 8'h56, 8'h78);
      n_tests++;
      if ({rsp_valid, rsp_op} !== {1'b1, 3'd0}) begin
         n_fail++;
         $display("FAIL nop_latency: rvalid=%b op=%h required 1/0", rsp_valid, rsp_op);
      end
      get_rsp(op, res, err);
      n_tests++;
      if ({op, res, err} !== {3'd0, 16'h0000, 1'b0}) begin
         n_fail++;
         $display("FAIL nop_rsp: op=%h res=%h err=%b required 0/0000/0", op, res, err);
      end
      get_rsp(op, res, err);
      n_tests++;
      if ({op, res, err} !== {3'd6, 16'h0000, 1'b1}) begin
         n_fail++;
         $display("FAIL illegal_rsp: op=%h res=%h err=%b required 6/0000/1", op, res, err);
      end
      n_tests++;
      if (start_cycles != s0) begin
         n_fail++;
         $display("FAIL nop_no_start: %0d start cycles, required 0", start_cycles - s0);
      end
   endtask

   task automatic test_timeout();
      logic [2:0] op; logic [15:0] res; logic err;
      int unsigned s0;
      alu_never = 1'b1; alu_lat = 2;
      s0 = start_cycles;
      push_cmd(3'd1, 8'h01, 8'h02);
      push_cmd(3'd3, 8'hF0, 8'h3C);
      get_rsp(op, res, err);
      alu_never = 1'b0;
      n_tests++;
      if ({op, res, err} !== {3'd1, 16'h0000, 1'b1}) begin
         n_fail++;
         $display("FAIL timeout_rsp: op=%h res=%h err=%b required 1/0000/1", op, res, err);
      end
      n_tests++;
      if (start_cycles - s0 != 15) begin
         n_fail++;
         $display("FAIL timeout_len: %0d cycles, required 15", start_cycles - s0);
      end
      get_rsp(op, res, err);
      n_tests++;
      if ({op, res, err} !== {3'd3, 16'h00CC, 1'b0}) begin
         n_fail++;
         $display("FAIL after_timeout_rsp: op=%h res=%h err=%b required 3/00cc/0", op, res, err);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  t_op  [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd1};
      logic [7:0]  t_a   [6] = '{8'h01, 8'hF0, 8'hF0, 8'h10, 8'h80, 8'h00};
      logic [7:0]  t_b   [6] = '{8'h02, 8'h3C, 8'h3C, 8'h10, 8'h80, 8'h00};
      logic [15:0] t_res [5] = '{16'h0003, 16'h0030, 16'h00CC, 16'h0100, 16'h0100};
      logic [2:0] op; logic [15:0] res; logic err;
      int unsigned idx = 0;
      logic rdy;
      alu_lat = 1; alu_never = 1'b0; rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (idx < 6) begin cmd_op = t_op[idx]; cmd_a = t_a[idx]; cmd_b = t_b[idx]; end
         rdy = cmd_ready;
         @(posedge clk);
         if (rdy && idx < 6) idx++;
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      n_tests++;
      if (idx != 5) begin
         n_fail++;
         $display("FAIL b2b_accepted: %0d commands, required 5", idx);
      end
      n_tests++;
      if ({cmd_ready, rsp_valid} !== 2'b01) begin
         n_fail++;
         $display("FAIL b2b_full: {rdy,rvalid}=%b required 01", {cmd_ready, rsp_valid});
      end
      for (int i = 0; i < 5; i++) begin
         get_rsp(op, res, err);
         n_tests++;
         if ({op, res, err} !== {t_op[i], t_res[i], 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_rsp%0d: op=%h res=%h err=%b required %h/%h/0",
                     i, op, res, err, t_op[i], t_res[i]);
         end
      end
      repeat (2) @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle: busy=%b required 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      bit seen_rsp = 1'b0;
      bit seen_start = 1'b0;
      alu_never = 1'b1;
      push_cmd(3'd1, 8'h11, 8'h22);
      push_cmd(3'd2, 8'h33, 8'h44);
      push_cmd(3'd3, 8'h55, 8'h66);
      n_tests++;
      if ({alu_start, busy} !== 2'b11) begin
         n_fail++;
         $display("FAIL rstmid_exec: {start,busy}=%b required 11", {alu_start, busy});
      end
      #2 reset_n = 1'b0;
      #1;
      n_tests++;
      if ({alu_start, busy, cmd_ready, rsp_valid} !== 4'b0010) begin
         n_fail++;
         $display("FAIL rstmid_async: {start,busy,rdy,rvalid}=%b required 0010",
                  {alu_start, busy, cmd_ready, rsp_valid});
      end
      @(negedge clk);
      reset_n = 1'b1;
      alu_never = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid) seen_rsp = 1'b1;
         if (alu_start) seen_start = 1'b1;
      end
      rsp_ready = 1'b0;
      n_tests++;
      if ({seen_rsp, seen_start, busy, cmd_ready} !== 4'b0001) begin
         n_fail++;
         $display("FAIL rstmid_after: {rsp_seen,start_seen,busy,rdy}=%b required 0001",
                  {seen_rsp, seen_start, busy, cmd_ready});
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_mul();
      test_nop_illegal();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tiny_alu_cmd_issuer.md
# tiny_alu_cmd_issuer

Command front-end that sits directly upstream of the tiny ALU. It accepts ALU commands over a valid/ready interface and buffers them in a small FIFO. It drives the ALU start/done handshake one command at a time and returns each result over a valid/ready response interface, with an error flag for illegal opcodes and ALU timeouts.

## Interface
- DATA_W, 8, operand width; result width is 2*DATA_W
- FIFO_DEPTH, 4, command FIFO entries (power of two, >= 2)
- TIMEOUT_CYC, 15, maximum cycles alu_start is held without alu_done before the command is aborted
- clk  in  1  single clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command can be accepted
- cmd_op  in  3  opcode (tiny_alu_pkg encodings)
- cmd_a, cmd_b  in  DATA_W  operands
- alu_start  out  1  ALU start, held high until alu_done or timeout
- alu_op  out  3  opcode to ALU
- alu_a, alu_b  out  DATA_W  operands to ALU
- alu_done  in  1  ALU completion strobe
- alu_result  in  2*DATA_W  ALU result, valid while alu_done=1
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_op  out  3  opcode of the completed command
- rsp_result  out  2*DATA_W  result; 0 on NOP or error
- rsp_err  out  1  1 = illegal opcode or timeout
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- Opcodes: NOP=0, ADD=1, AND=2, XOR=3, MUL=4. Opcodes 5–7 are illegal.
- Command FIFO: a push occurs when cmd_valid && cmd_ready. cmd_ready = !full; it depends on fullness only, so a full FIFO rejects a push even when a pop happens in the same cycle.
- FSM states: IDLE, EXEC, RESP.
- IDLE: if the FIFO is non-empty, pop the head into the command register.
  - Legal, non-NOP opcode: go to EXEC.
  - NOP or illegal opcode: go to RESP directly. rsp_err = illegal, rsp_result = 0. alu_start is never asserted.
- EXEC: alu_start=1 and alu_op/a/b are driven from the command register, stable for the whole state. The timeout counter increments each cycle.
  - alu_done=1: capture alu_result, go to RESP with rsp_err=0.
  - Counter reaches TIMEOUT_CYC without alu_done: go to RESP with rsp_err=1 and rsp_result=0.
- RESP: rsp_valid=1; rsp_op/result/err are stable until the handshake. On rsp_valid && rsp_ready, return to IDLE.
- alu_done outside EXEC is ignored.
- Commands are processed strictly in order; no reordering and no overlap.

## Timing
- Reset values: cmd_ready=1, alu_start=0, alu_op/a/b=0, rsp_valid=0, rsp_op/result/err=0, busy=0. The FIFO is emptied and the FSM goes to IDLE.
- Reset asserted mid-operation discards all buffered and in-flight commands. alu_start falls asynchronously with reset.
- Command latency (empty FIFO, FSM in IDLE, command accepted at edge k):
  - FIFO non-empty after edge k.
  - Pop at edge k+1; alu_start high after edge k+1.
- Completion latency:
  - alu_done sampled high at edge m: alu_start low and rsp_valid high after edge m.
  - Response handshake at edge r: IDLE after edge r.
  - Next pop no earlier than edge r+1.
- NOP or illegal opcode: rsp_valid high one cycle after the pop edge.
- Timeout: if alu_start rises after edge s and alu_done never arrives, rsp_valid (err=1) rises after edge s+TIMEOUT_CYC.
- Throughput: at most one command per (ALU latency + 2) cycles when rsp_ready=1.
- All outputs are registered except cmd_ready and busy, which are combinational from registered state.

## Structure
- tiny_alu_pkg gains:
  - the issuer state enum typedef (IDLE, EXEC, RESP);
  - function is_legal_op(op) returning 1 for opcodes 0–4;
  - a command struct typedef (op, a, b), parameterised by DATA_W through the package constant.
- Sub-module tiny_alu_cmd_fifo: synchronous FIFO with the same async active-low reset, push/pop/full/empty, parameters FIFO_DEPTH and entry width. Top-level FSM and timeout counter stay in tiny_alu_cmd_issuer.

## Test plan
- ADD, a=8'hFF, b=8'h01, ALU model done after 1 cycle -> one alu_start pulse; rsp_result=16'h0100, rsp_err=0, rsp_op=1.
- MUL, a=8'hFF, b=8'hFF, ALU model done after 3 cycles -> alu_start high 3 cycles; rsp_result=16'hFE01.
- NOP, then opcode 3'd6 -> alu_start never asserts; two responses: (op=0, result=0, err=0), then (op=6, result=0, err=1).
- ALU model never asserts done, ADD issued -> alu_start high exactly 15 cycles; rsp_err=1, rsp_result=0; next queued XOR 8'hF0^8'h3C returns 16'h00CC.
- rsp_ready=0, cmd_valid held high -> 5 commands accepted (1 in flight + 4 buffered), then cmd_ready=0; releasing rsp_ready drains responses in issue order.
- reset_n asserted while in EXEC with 2 commands buffered -> alu_start falls immediately; after release busy=0, cmd_ready=1, and no stale response appears.
